// File: rtl/field_pkg.sv
// Shared definitions for the field RAM producers and consumers.
// Contents: RAM word width, unpacked word layout, reader FSM states and
// an address-width helper that never returns zero.
package field_pkg;

    localparam int FIELD_DATAW = 96;

    // RAM word layout: [95:64] = xn, [63:32] = yn, [31:0] = mag.
    typedef struct packed {
        logic [31:0] xn;
        logic [31:0] yn;
        logic [31:0] mag;
    } field_word_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } rd_state_t;

    // A 1-cell field still needs a 1-bit address port.
    function automatic int addr_width(input int size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

endpackage

// File: rtl/field_skid_fifo.sv
// Two-entry FIFO that absorbs the RAM read latency when the stream stalls.
// Ports:
//   clk, reset_n     clock, async active-low reset
//   push, din        write one word (accepted when not full, or full with pop)
//   pop, dout        dout is the head word; pop removes it (ignored when empty)
//   count            occupancy 0..2
//   empty, full      occupancy flags
module field_skid_fifo #(
    parameter int WIDTH = 96
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic [1:0]       count,
    output logic             empty,
    output logic             full
);

    logic [WIDTH-1:0] mem_r [2];
    logic             wr_ptr_r;
    logic             rd_ptr_r;
    logic [1:0]       count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign empty     = (count_r == 2'd0);
    assign full      = (count_r == 2'd2);
    assign pop_ok_s  = pop & ~empty;
    // When full, a simultaneous pop frees the slot the write pointer lands on.
    assign push_ok_s = push & (~full | pop_ok_s);
    assign dout      = mem_r[rd_ptr_r];
    assign count     = count_r;

    // Storage, pointers and occupancy; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 2; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            wr_ptr_r <= 1'b0;
            rd_ptr_r <= 1'b0;
            count_r  <= 2'd0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= ~wr_ptr_r;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ~rd_ptr_r;
            end
            count_r <= count_r + {1'b0, push_ok_s} - {1'b0, pop_ok_s};
        end
    end

endmodule

// File: rtl/field_stream_reader.sv
// Scans the whole field RAM in address order and streams each word, unpacked
// into {xn, yn, mag} and tagged with its cell (x, y), on a valid/ready port.
// Ports:
//   clk, reset_n          clock, async active-low reset
//   start / busy / done   scan handshake (done is a 1-cycle pulse)
//   field_addr_read,
//   field_re,
//   field_data_out        RAM read port, data valid 1 cycle after field_re
//   out_valid, out_ready  stream handshake
//   out_xn/yn/mag         unpacked word, out_x/out_y cell, out_last final cell
module field_stream_reader
    import field_pkg::*;
#(
    parameter  int FIELD_WIDTH  = 8,
    parameter  int FIELD_HEIGHT = 6,
    localparam int FIELD_SIZE   = FIELD_WIDTH * FIELD_HEIGHT,
    localparam int FIELD_ADDRW  = addr_width(FIELD_SIZE)
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   start,
    output logic                   busy,
    output logic                   done,
    output logic [FIELD_ADDRW-1:0] field_addr_read,
    output logic                   field_re,
    input  logic [FIELD_DATAW-1:0] field_data_out,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [31:0]            out_xn,
    output logic [31:0]            out_yn,
    output logic [31:0]            out_mag,
    output logic [15:0]            out_x,
    output logic [15:0]            out_y,
    output logic                   out_last
);

    localparam logic [FIELD_ADDRW-1:0] ADDR_MAX = FIELD_ADDRW'(FIELD_SIZE - 1);
    localparam logic [15:0]            X_MAX    = 16'(FIELD_WIDTH - 1);
    localparam logic [15:0]            Y_MAX    = 16'(FIELD_HEIGHT - 1);

    rd_state_t              state_r;
    logic [FIELD_ADDRW-1:0] addr_r;
    logic [15:0]            x_r;
    logic [15:0]            y_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   inflight_r;

    field_word_t            head_s;
    logic [1:0]             fifo_count_s;
    logic                   fifo_empty_s;
    logic                   fifo_full_s;
    logic                   pop_s;
    logic                   issue_s;
    logic                   last_s;
    logic [2:0]             occ_s;

    field_skid_fifo #(
        .WIDTH ($bits(field_word_t))
    ) u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (inflight_r),
        .pop     (pop_s),
        .din     (field_data_out),
        .dout    (head_s),
        .count   (fifo_count_s),
        .empty   (fifo_empty_s),
        .full    (fifo_full_s)
    );

    assign pop_s = ~fifo_empty_s & out_ready;

    // Words held plus the one in flight, minus the one leaving this cycle, must
    // stay below the FIFO depth so the word issued now always has a slot. The
    // issue decision is combinational so a pop can be refilled in the same
    // cycle, which is what gives one beat per clock with only two entries.
    assign occ_s   = {1'b0, fifo_count_s} + {2'b00, inflight_r};
    assign issue_s = (state_r == READ) &&
                     (occ_s < (3'd2 + {2'b00, pop_s})) &&
                     ~(fifo_full_s & ~pop_s);

    assign last_s = ~fifo_empty_s && (x_r == X_MAX) && (y_r == Y_MAX);

    assign busy            = busy_r;
    assign done            = done_r;
    assign field_addr_read = addr_r;
    assign field_re        = issue_s;
    assign out_valid       = ~fifo_empty_s;
    assign out_xn          = head_s.xn;
    assign out_yn          = head_s.yn;
    assign out_mag         = head_s.mag;
    assign out_x           = x_r;
    assign out_y           = y_r;
    assign out_last        = last_s;

    // Scan sequencing: address issue, busy/done handshake and in-flight tracking.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            addr_r     <= {FIELD_ADDRW{1'b0}};
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
            inflight_r <= 1'b0;
        end else begin
            inflight_r <= issue_s;
            done_r     <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (start) begin
                        state_r <= READ;
                        busy_r  <= 1'b1;
                        addr_r  <= {FIELD_ADDRW{1'b0}};
                    end
                end
                READ: begin
                    if (issue_s) begin
                        if (addr_r == ADDR_MAX) begin
                            state_r <= DRAIN;
                        end else begin
                            addr_r <= addr_r + FIELD_ADDRW'(1);
                        end
                    end
                end
                DRAIN: begin
                    // The last cell is the last word issued, so its acceptance
                    // means the FIFO and the read pipeline are both empty.
                    if (pop_s && last_s) begin
                        state_r <= DONE;
                        busy_r  <= 1'b0;
                        done_r  <= 1'b1;
                    end
                end
                DONE: begin
                    state_r <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // Cell coordinates follow accepted beats; x wraps into a y increment.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            x_r <= 16'd0;
            y_r <= 16'd0;
        end else if ((state_r == IDLE) && start) begin
            x_r <= 16'd0;
            y_r <= 16'd0;
        end else if (pop_s) begin
            if (x_r == X_MAX) begin
                x_r <= 16'd0;
                if (y_r == Y_MAX) begin
                    y_r <= 16'd0;
                end else begin
                    y_r <= y_r + 16'd1;
                end
            end else begin
                x_r <= x_r + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_field_stream_reader.sv
// Self-checking bench for field_stream_reader: an 8x6 instance driven from a
// scenario table plus hand-written reset and 1x1 geometry sequences.
// The reference is the plain rule "beat i carries word i at (i%8, i/8)".
module tb_field_stream_reader;
    import field_pkg::*;

    localparam int W    = 8;
    localparam int H    = 6;
    localparam int SIZE = W * H;
    localparam int AW   = 6;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_n;
    logic          start;
    logic          out_ready;
    logic          busy;
    logic          done;
    logic [AW-1:0] field_addr_read;
    logic          field_re;
    logic [95:0]   field_data_out = '0;
    logic          out_valid;
    logic [31:0]   out_xn, out_yn, out_mag;
    logic [15:0]   out_x, out_y;
    logic          out_last;

    logic          s_start;
    logic          s_ready;
    logic          s_busy;
    logic          s_done;
    logic [0:0]    s_addr;
    logic          s_re;
    logic [95:0]   s_data = '0;
    logic          s_valid;
    logic [31:0]   s_xn, s_yn, s_mag;
    logic [15:0]   s_x, s_y;
    logic          s_last;

    logic [95:0]   ram [SIZE];

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        int ready_pct;
        int stall;
        int xs0;
        int xs1;
        int exp_first;
        int exp_done;
    } scen_t;

    scen_t tbl [5];
    string tbl_name [5];

    field_stream_reader #(.FIELD_WIDTH(W), .FIELD_HEIGHT(H)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (start),
        .busy            (busy),
        .done            (done),
        .field_addr_read (field_addr_read),
        .field_re        (field_re),
        .field_data_out  (field_data_out),
        .out_valid       (out_valid),
        .out_ready       (out_ready),
        .out_xn          (out_xn),
        .out_yn          (out_yn),
        .out_mag         (out_mag),
        .out_x           (out_x),
        .out_y           (out_y),
        .out_last        (out_last)
    );

    field_stream_reader #(.FIELD_WIDTH(1), .FIELD_HEIGHT(1)) dut1 (
        .clk             (clk),
        .reset_n         (reset_n),
        .start           (s_start),
        .busy            (s_busy),
        .done            (s_done),
        .field_addr_read (s_addr),
        .field_re        (s_re),
        .field_data_out  (s_data),
        .out_valid       (s_valid),
        .out_ready       (s_ready),
        .out_xn          (s_xn),
        .out_yn          (s_yn),
        .out_mag         (s_mag),
        .out_x           (s_x),
        .out_y           (s_y),
        .out_last        (s_last)
    );

    // Behavioural RAMs with one cycle of read latency.
    always @(posedge clk) begin
        if (field_re) field_data_out <= ram[int'(field_addr_read)];
    end

    always @(posedge clk) begin
        if (s_re) s_data <= ram[int'(s_addr)];
    end

    task automatic chk(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One scan of the 8x6 instance; n counts edges after the edge that samples start.
    task automatic run_scan(input string name, input scen_t s);
        int n, issued, accepted, done_cnt, done_n, first_n, max_occ, occ;
        logic hold, diff;
        logic [31:0] h_xn, h_yn, h_mag;
        logic [15:0] h_x, h_y;
        logic h_last;
        issued = 0; accepted = 0; done_cnt = 0; done_n = -1; first_n = -1;
        max_occ = 0; hold = 1'b0;
        h_xn = '0; h_yn = '0; h_mag = '0; h_x = '0; h_y = '0; h_last = 1'b0;
        start = 1'b1;
        out_ready = 1'b0;
        step();
        start = 1'b0;
        n = 0;
        while (n < 3000) begin
            out_ready = (n < s.stall) ? 1'b0 :
                        ((s.ready_pct >= 100) ? 1'b1 : (int'($urandom_range(99)) < s.ready_pct));
            start = (n == s.xs0) || (n == s.xs1);
            #1;
            if (n == 0) chk({name, " busy_at_start"}, longint'(busy), 1);
            if (field_re) begin
                chk({name, " addr_order"}, longint'(field_addr_read), longint'(issued));
                issued++;
            end
            if ((s.stall > 0) && (n == s.stall - 1)) chk({name, " issues_during_stall"}, issued, 2);
            if (out_valid && (first_n < 0)) first_n = n;
            if (hold) begin
                diff = (out_valid !== 1'b1) || (out_xn !== h_xn) || (out_yn !== h_yn) ||
                       (out_mag !== h_mag) || (out_x !== h_x) || (out_y !== h_y) ||
                       (out_last !== h_last);
                chk({name, " stable_while_stalled"}, longint'(diff), 0);
            end
            if (out_valid && out_ready) begin
                if (accepted < SIZE) begin
                    chk({name, " beat_xn"},  longint'(out_xn),  accepted);
                    chk({name, " beat_yn"},  longint'(out_yn),  accepted + 100);
                    chk({name, " beat_mag"}, longint'(out_mag), accepted + 200);
                    chk({name, " beat_x"},   longint'(out_x),   accepted % W);
                    chk({name, " beat_y"},   longint'(out_y),   accepted / W);
                    chk({name, " beat_last"}, longint'(out_last), (accepted == SIZE - 1) ? 1 : 0);
                end
                accepted++;
            end
            hold = out_valid && !out_ready;
            h_xn = out_xn; h_yn = out_yn; h_mag = out_mag;
            h_x = out_x; h_y = out_y; h_last = out_last;
            occ = issued - accepted;
            if (occ > max_occ) max_occ = occ;
            if (done) begin
                done_cnt++;
                if (done_n < 0) begin
                    done_n = n;
                    chk({name, " busy_at_done"}, longint'(busy), 0);
                    chk({name, " valid_at_done"}, longint'(out_valid), 0);
                end
            end
            if ((done_n >= 0) && (n >= done_n + 2)) break;
            step();
            n++;
        end
        start = 1'b0;
        chk({name, " beats_accepted"}, accepted, SIZE);
        chk({name, " reads_issued"}, issued, SIZE);
        chk({name, " done_pulses"}, done_cnt, 1);
        chk({name, " occupancy_le_2"}, (max_occ <= 2) ? 1 : 0, 1);
        if (s.exp_first >= 0) chk({name, " first_valid_cycle"}, first_n, s.exp_first);
        if (s.exp_done >= 0) chk({name, " done_cycle"}, done_n, s.exp_done);
        chk({name, " idle_busy"}, longint'(busy), 0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int beats1, done1_n;

        //            pct stall xs0 xs1 first done
        tbl[0] = '{100,  0, -1, -1,  2,  50}; tbl_name[0] = "free_flow";
        tbl[1] = '{ 30,  0, -1, -1,  2,  -1}; tbl_name[1] = "backpressure";
        tbl[2] = '{100, 20, -1, -1,  2,  68}; tbl_name[2] = "stall_release";
        tbl[3] = '{100,  0,  5, 30,  2,  50}; tbl_name[3] = "start_while_busy";
        tbl[4] = '{100,  0, -1, -1,  2,  50}; tbl_name[4] = "rescan_after_done";

        for (int i = 0; i < SIZE; i++) begin
            ram[i] = {32'(i), 32'(i + 100), 32'(i + 200)};
        end

        reset_n = 1'b0; start = 1'b0; out_ready = 1'b0; s_start = 1'b0; s_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_busy", longint'(busy), 0);
        chk("reset_done", longint'(done), 0);
        chk("reset_valid", longint'(out_valid), 0);
        chk("reset_re", longint'(field_re), 0);
        chk("reset_addr", longint'(field_addr_read), 0);
        chk("reset_xy", longint'({out_x, out_y}), 0);
        chk("reset_last", longint'(out_last), 0);
        chk("reset_last_1x1", longint'(s_last), 0);
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 5; i++) begin
            run_scan(tbl_name[i], tbl[i]);
        end

        // Reset asserted for 2 cycles right after beat 20 is accepted.
        out_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        acc = 0;
        for (int n = 0; n < 200; n++) begin
            if (out_valid && out_ready) acc++;
            if (acc == 21) break;
            step();
        end
        chk("midreset_reached_beat20", acc, 21);
        reset_n = 1'b0;
        #1;
        chk("midreset_busy", longint'(busy), 0);
        chk("midreset_valid", longint'(out_valid), 0);
        chk("midreset_re", longint'(field_re), 0);
        chk("midreset_addr", longint'(field_addr_read), 0);
        chk("midreset_xy", longint'({out_x, out_y}), 0);
        chk("midreset_payload", longint'(out_xn | out_yn | out_mag), 0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        repeat (3) step();
        chk("postreset_valid", longint'(out_valid), 0);
        chk("postreset_busy", longint'(busy), 0);
        run_scan("restart_after_reset", tbl[0]);

        // 1x1 geometry: one beat, last set, done right after it.
        s_ready = 1'b1;
        s_start = 1'b1;
        step();
        s_start = 1'b0;
        beats1 = 0;
        done1_n = -1;
        for (int n = 0; n < 20; n++) begin
            if (s_valid && s_ready) begin
                beats1++;
                chk("g1x1_x", longint'(s_x), 0);
                chk("g1x1_y", longint'(s_y), 0);
                chk("g1x1_last", longint'(s_last), 1);
                chk("g1x1_xn", longint'(s_xn), 0);
                chk("g1x1_mag", longint'(s_mag), 200);
            end
            if (s_done && (done1_n < 0)) done1_n = n;
            step();
        end
        chk("g1x1_beats", beats1, 1);
        chk("g1x1_done_cycle", done1_n, 3);
        chk("g1x1_idle_busy", longint'(s_busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
